// File: rtl/count_arb_if.sv
// Bundle of the request/length/grant/status signals shared between the
// requesters and the count_arb shared-counter arbiter.
interface count_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        cnt;

  // Requester side: drives requests and run lengths, observes status.
  modport master (
    output req,
    output len,
    input  gnt,
    input  done,
    input  busy,
    input  cnt
  );

  // Arbiter side: samples requests and lengths, drives grant and counter.
  modport slave (
    input  req,
    input  len,
    output gnt,
    output done,
    output busy,
    output cnt
  );
endinterface

// File: rtl/count_arb.sv
// count_arb: NREQ requesters share one 8-bit counter. A winner is picked in
// IDLE, its length is latched as the target, the counter runs 0..target,
// then a one-cycle done pulse is returned to the owner.
// Optional feature: define COUNT_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer register.
module count_arb #(
  parameter int NREQ = 4
) (
  input  logic        clk,
  input  logic        rst,
  count_arb_if.slave  arb
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        target_q, target_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic [7:0]        win_len;

`ifdef COUNT_ARB_RR_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W:0]    rr_sum;
`endif

  // Winner selection: scan requesters starting at the pointer (round-robin)
  // or at index 0 (fixed priority); the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_len   = '0;
    scan_idx  = '0;
`ifdef COUNT_ARB_RR_EN
    rr_sum    = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef COUNT_ARB_RR_EN
      // ptr + k stays below 2*NREQ, so one conditional subtract wraps it.
      rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NREQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NREQ);
      end
      scan_idx = rr_sum[IDX_W-1:0];
`else
      scan_idx = IDX_W'(k);
`endif
      if (!win_found && arb.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_len   = arb.len[{scan_idx, 3'b000} +: 8];
      end
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    gnt_d    = gnt_q;
`ifdef COUNT_ARB_RR_EN
    ptr_d    = ptr_q;
    owner_d  = owner_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        gnt_d = '0;
        if (win_found) begin
          gnt_d[win_idx] = 1'b1;
          target_d       = win_len;
          state_d        = S_RUN;
`ifdef COUNT_ARB_RR_EN
          owner_d        = win_idx;
`endif
        end
      end
      S_RUN: begin
        // Counting stops at the target, so cnt can never wrap past 255.
        if (cnt_q == target_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
`ifdef COUNT_ARB_RR_EN
        if (owner_q == IDX_W'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = owner_q + IDX_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      gnt_q    <= '0;
`ifdef COUNT_ARB_RR_EN
      ptr_q    <= '0;
      owner_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      gnt_q    <= gnt_d;
`ifdef COUNT_ARB_RR_EN
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
`endif
    end
  end

  assign arb.gnt  = gnt_q;
  assign arb.done = (state_q == S_DONE) ? gnt_q : '0;
  assign arb.busy = (state_q != S_IDLE);
  assign arb.cnt  = cnt_q;

endmodule

// File: tb/tb_count_arb.sv
// Directed testbench for count_arb (NREQ = 4). Expected grant order in the
// contention scenario follows COUNT_ARB_RR_EN when it is defined.
module tb_count_arb;

  localparam int NREQ = 4;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  count_arb_if #(.NREQ(NREQ)) bus_if ();

  count_arb #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.req = '0;
    bus_if.len = '0;
    apply_reset();
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.done !== 4'b0000 ||
        bus_if.busy !== 1'b0 || bus_if.cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: gnt=%b done=%b busy=%b cnt=%0d, need gnt=0000 done=0000 busy=0 cnt=0",
               bus_if.gnt, bus_if.done, bus_if.busy, bus_if.cnt);
    end else $display("[TB] reset_state ok");
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.cnt !== 8'd0 || bus_if.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_no_req: busy=%b cnt=%0d gnt=%b, need 0/0/0000",
               bus_if.busy, bus_if.cnt, bus_if.gnt);
    end else $display("[TB] idle_no_req ok");
  endtask

  task automatic test_single_run();
    int errs;
    bus_if.len[7:0] = 8'd10;
    bus_if.req      = 4'b0001;
    tick();
    tests_run++;
    if (bus_if.gnt !== 4'b0001 || bus_if.cnt !== 8'd0 || bus_if.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%b cnt=%0d busy=%b, need 0001/0/1",
               bus_if.gnt, bus_if.cnt, bus_if.busy);
    end else $display("[TB] single_grant ok");
    bus_if.req = 4'b0000;
    errs = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if ((bus_if.cnt !== 8'(k) || bus_if.done !== 4'b0000) && errs == 0) begin
        errs++;
        $display("FAIL single_count: step %0d cnt=%0d done=%b, need cnt=%0d done=0000",
                 k, bus_if.cnt, bus_if.done, k);
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
    else $display("[TB] single_count ok");
    tick();
    tests_run++;
    if (bus_if.done !== 4'b0001 || bus_if.gnt !== 4'b0001 || bus_if.cnt !== 8'd10) begin
      tests_failed++;
      $display("FAIL single_done: done=%b gnt=%b cnt=%0d, need 0001/0001/10",
               bus_if.done, bus_if.gnt, bus_if.cnt);
    end else $display("[TB] single_done ok");
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 4'b0000 ||
        bus_if.gnt !== 4'b0000 || bus_if.cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL single_idle: busy=%b done=%b gnt=%b cnt=%0d, need 0/0000/0000/0",
               bus_if.busy, bus_if.done, bus_if.gnt, bus_if.cnt);
    end else $display("[TB] single_idle ok");
  endtask

  task automatic test_zero_len();
    bus_if.len[15:8] = 8'd0;
    bus_if.req       = 4'b0010;
    tick();
    bus_if.req = 4'b0000;
    tests_run++;
    if (bus_if.gnt !== 4'b0010 || bus_if.cnt !== 8'd0 || bus_if.done !== 4'b0000) begin
      tests_failed++;
      $display("FAIL zero_run: gnt=%b cnt=%0d done=%b, need 0010/0/0000",
               bus_if.gnt, bus_if.cnt, bus_if.done);
    end else $display("[TB] zero_run ok");
    tick();
    tests_run++;
    if (bus_if.done !== 4'b0010 || bus_if.cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL zero_done: done=%b cnt=%0d, need 0010/0", bus_if.done, bus_if.cnt);
    end else $display("[TB] zero_done ok");
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 4'b0000) begin
      tests_failed++;
      $display("FAIL zero_idle: busy=%b done=%b, need 0/0000", bus_if.busy, bus_if.done);
    end else $display("[TB] zero_idle ok");
  endtask

  task automatic test_contention();
    logic [3:0] exp_gnt [5];
`ifdef COUNT_ARB_RR_EN
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    bus_if.req = 4'b0000;
    apply_reset();
    bus_if.len = {8'd2, 8'd2, 8'd2, 8'd2};
    bus_if.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      tests_run++;
      if (bus_if.gnt !== exp_gnt[r]) begin
        tests_failed++;
        $display("FAIL contention_gnt run %0d: gnt=%b, need %b", r, bus_if.gnt, exp_gnt[r]);
      end else $display("[TB] contention run %0d gnt=%b ok", r, bus_if.gnt);
      tick();
      tick();
      tick();
      tests_run++;
      if (bus_if.done !== exp_gnt[r] || bus_if.cnt !== 8'd2) begin
        tests_failed++;
        $display("FAIL contention_done run %0d: done=%b cnt=%0d, need %b/2",
                 r, bus_if.done, bus_if.cnt, exp_gnt[r]);
      end
      tick();
      tests_run++;
      if (bus_if.busy !== 1'b0 || bus_if.gnt !== 4'b0000) begin
        tests_failed++;
        $display("FAIL contention_idle run %0d: busy=%b gnt=%b, need 0/0000",
                 r, bus_if.busy, bus_if.gnt);
      end
    end
    bus_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    bus_if.len[23:16] = 8'd50;
    bus_if.req        = 4'b0100;
    tick();
    bus_if.req = 4'b0000;
    for (int k = 0; k < 20; k++) tick();
    tests_run++;
    if (bus_if.cnt !== 8'd20 || bus_if.gnt !== 4'b0100) begin
      tests_failed++;
      $display("FAIL midrun_count: cnt=%0d gnt=%b, need 20/0100", bus_if.cnt, bus_if.gnt);
    end else $display("[TB] midrun_count ok");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus_if.gnt !== 4'b0000 || bus_if.cnt !== 8'd0 ||
        bus_if.busy !== 1'b0 || bus_if.done !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrun_reset: gnt=%b cnt=%0d busy=%b done=%b, need 0000/0/0/0000",
               bus_if.gnt, bus_if.cnt, bus_if.busy, bus_if.done);
    end else $display("[TB] midrun_reset ok");
    tick();
    tests_run++;
    if (bus_if.done !== 4'b0000 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_after: done=%b busy=%b, need 0000/0", bus_if.done, bus_if.busy);
    end else $display("[TB] midrun_after ok");
  endtask

  task automatic test_len255_stability();
    int errs;
    apply_reset();
    bus_if.len[31:24] = 8'd255;
    bus_if.req        = 4'b1000;
    tick();
    tests_run++;
    if (bus_if.gnt !== 4'b1000 || bus_if.cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL max_grant: gnt=%b cnt=%0d, need 1000/0", bus_if.gnt, bus_if.cnt);
    end else $display("[TB] max_grant ok");
    // Disturb the inputs; the latched target must govern the run.
    bus_if.len[31:24] = 8'd5;
    bus_if.req        = 4'b0000;
    errs = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if ((bus_if.cnt !== 8'(k) || bus_if.done !== 4'b0000) && errs == 0) begin
        errs++;
        $display("FAIL max_count: step %0d cnt=%0d done=%b, need cnt=%0d done=0000",
                 k, bus_if.cnt, bus_if.done, k);
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
    else $display("[TB] max_count ok");
    tick();
    tests_run++;
    if (bus_if.done !== 4'b1000 || bus_if.cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL max_done: done=%b cnt=%0d, need 1000/255", bus_if.done, bus_if.cnt);
    end else $display("[TB] max_done ok");
    tick();
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.cnt !== 8'd0 || bus_if.done !== 4'b0000) begin
      tests_failed++;
      $display("FAIL max_idle: busy=%b cnt=%0d done=%b, need 0/0/0000",
               bus_if.busy, bus_if.cnt, bus_if.done);
    end else $display("[TB] max_idle ok");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus_if.req   = '0;
    bus_if.len   = '0;
    test_reset();
    test_single_run();
    test_zero_len();
    test_contention();
    test_reset_mid_run();
    test_len255_stability();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/count_arb.md
COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port req  input  NREQ  per-requester level request for a count run.
REQ-005 Port len  input  8*NREQ  packed run lengths; requester i uses len[8*i+7:8*i].
REQ-006 Port gnt  output  NREQ  one-hot owner of the shared counter; all-zero when not owned.
REQ-007 Port done  output  NREQ  one-cycle completion pulse to the owner.
REQ-008 Port busy  output  1  high in RUN and DONE states.
REQ-009 Port cnt  output  8  shared counter value.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 IDLE, no req bit set: the block SHALL stay in IDLE with cnt, gnt and done at 0.
REQ-012 IDLE, any req bit set: the block SHALL, at the next edge, select one winner, set gnt to the winner (one-hot), latch the winner's len into an internal target, clear cnt to 0 and enter RUN.
REQ-013 RUN, cnt != target: the block SHALL increment cnt by 1 per cycle.
REQ-014 RUN, cnt == target: the block SHALL enter DONE at the next edge, holding cnt.
REQ-015 DONE: the block SHALL assert done[owner] for exactly one cycle with gnt still set, then clear gnt and cnt and return to IDLE at the next edge.
REQ-016 Timing: gnt rises one cycle after req is sampled in IDLE; done rises len+1 cycles after gnt rises.
REQ-017 len = 0: the block SHALL spend exactly one RUN cycle (cnt = 0) before DONE.
REQ-018 len = 255: cnt SHALL reach 255 and SHALL never wrap to 0 within a run.
REQ-019 len and req changes after the grant SHALL NOT affect the current run; a deasserted req SHALL NOT abort the run.
REQ-020 New requests SHALL only be arbitrated in IDLE, so at most one grant exists per run and at least one IDLE cycle separates back-to-back runs.
REQ-021 Simultaneous requests SHALL be resolved by the policy in REQ-024/REQ-025; requests not granted SHALL remain pending as long as req stays high.
REQ-022 At most one gnt bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-023 When rst is high at an edge, the block SHALL enter IDLE with gnt = 0, done = 0, busy = 0, cnt = 0, target = 0 and the round-robin pointer = 0; this applies from any state, including mid-run, and drops the run with no done pulse.

Configuration
REQ-024 With macro COUNT_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at the pointer index and proceeds upward with wrap-around, and on DONE the pointer SHALL become owner+1 modulo NREQ.
REQ-025 With COUNT_ARB_RR_EN undefined, arbitration SHALL be fixed priority with the lowest index winning, and no pointer register SHALL exist.

Verification
REQ-026 Single run: after reset, req = 0001 with len0 = 10 -> gnt = 0001 next cycle; cnt counts 0..10; done[0] pulses 11 cycles after gnt rises; busy falls after the pulse.
REQ-027 Zero length: req = 0010 with len1 = 0 -> one RUN cycle with cnt = 0, then done[1] pulse, then IDLE.
REQ-028 Contention, COUNT_ARB_RR_EN defined: req = 1111 held, all len = 2 -> grant order 0, 1, 2, 3, 0, with one IDLE cycle between runs. Same stimulus without the macro -> requester 0 is granted every run.
REQ-029 Reset mid-run: req = 0100 with len2 = 50, rst pulsed while cnt = 20 -> the next cycle shows gnt = 0, cnt = 0, busy = 0 and no done pulse.
REQ-030 Boundary and stability: len3 = 255 run completes with cnt peaking at 255 and no wrap; changing len3 and dropping req mid-run leaves the done timing unchanged (256 cycles after gnt).
